// File: rtl/sar_r2r_adc_if.sv
// Signal bundle between the SAR controller and its R2R DAC / comparator front end.
// The slave modport is the controller; the master side drives enable and the comparator.
interface sar_r2r_adc_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic             comp_in;
    logic [WIDTH-1:0] R2R_out;
    logic [WIDTH-1:0] sar_data;
    logic             data_valid;
    logic             busy;

    modport master (
        output enable,
        output comp_in,
        input  R2R_out,
        input  sar_data,
        input  data_valid,
        input  busy
    );

    modport slave (
        input  enable,
        input  comp_in,
        output R2R_out,
        output sar_data,
        output data_valid,
        output busy
    );
endinterface

// File: rtl/sar_r2r_adc.sv
// Successive-approximation controller for an external R2R DAC plus analog comparator.
// One conversion per sample tick while enabled; result published with a one-cycle strobe.
module sar_r2r_adc #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SAMPLE_PERIOD = 100_000
) (
    input logic          clk,
    input logic          reset,
    sar_r2r_adc_if.slave bus
);
    localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES + SYNC_STAGES > 1) ?
                                    $clog2(SETTLE_CYCLES + SYNC_STAGES) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] TICK_AT     = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES + SYNC_STAGES - 1);
    localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       trial_q, trial_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SET_W-1:0]       settle_q, settle_d;
    logic [WIDTH-1:0]       sar_q, sar_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   tick;
    logic                   comp_sync;

    assign tick      = (cnt_q == TICK_AT);
    assign cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    assign comp_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        sar_d    = sar_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (tick && bus.enable) begin
                    trial_d  = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_d    = MSB_IDX;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_DECIDE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_DECIDE: begin
                // Comparator low means the trial overshot Vin: drop the bit under test.
                if (!comp_sync) begin
                    trial_d[idx_q] = 1'b0;
                end
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    trial_d[idx_q - IDX_W'(1)] = 1'b1;
                    idx_d    = idx_q - IDX_W'(1);
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                sar_d   = trial_q;
                valid_d = 1'b1;
                busy_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            sync_q   <= '0;
            state_q  <= ST_IDLE;
            trial_q  <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            sar_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.comp_in};
            state_q  <= state_d;
            trial_q  <= trial_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            sar_q    <= sar_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.R2R_out    = trial_q;
    assign bus.sar_data   = sar_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sar_r2r_adc.sv
// Directed + randomized bench for sar_r2r_adc with an ideal comparator model per instance.
// Instance a uses a 100-cycle sample period, instance b a 40-cycle period shorter than a conversion.
module tb_sar_r2r_adc;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] vin_a = 8'h00;
    logic [7:0] vin_b = 8'h00;

    int vectors = 0;
    int miscompares = 0;
    int since = 0;
    int valid_cnt = 0;

    sar_r2r_adc_if bus_a ();
    sar_r2r_adc_if bus_b ();

    sar_r2r_adc #(
        .WIDTH(8), .SETTLE_CYCLES(4), .SYNC_STAGES(2), .SAMPLE_PERIOD(100)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    sar_r2r_adc #(
        .WIDTH(8), .SETTLE_CYCLES(4), .SYNC_STAGES(2), .SAMPLE_PERIOD(40)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Ideal comparator with one cycle of analog delay.
    always @(posedge clk) begin
        bus_a.comp_in <= (vin_a >= bus_a.R2R_out);
        bus_b.comp_in <= (vin_b >= bus_b.R2R_out);
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Trial code i holds Vin's bits above the probe bit plus the probe bit itself.
    function automatic logic [7:0] model_trial(input logic [7:0] vin, input int i);
        logic [7:0] probe;
        logic [7:0] above;
        probe = 8'h80;
        probe = probe >> i;
        above = ~((probe << 1) - 8'd1);
        return (vin & above) | probe;
    endfunction

    task automatic step();
        @(negedge clk);
        since++;
        if (bus_a.data_valid) valid_cnt++;
    endtask

    task automatic wait_start(input int exp_wait);
        int k;
        k = 0;
        while (!bus_a.busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (exp_wait >= 0) check("start_latency", k, exp_wait);
        else check("start_seen", int'(bus_a.busy), 1);
        since = 0;
        valid_cnt = 0;
    endtask

    task automatic run_conv(input logic [7:0] vin, input int exp_wait);
        vin_a = vin;
        wait_start(exp_wait);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) repeat (7) step();
            check($sformatf("trial%0d_%02h", i, vin), int'(bus_a.R2R_out),
                  int'(model_trial(vin, i)));
        end
        while (!bus_a.data_valid && since < 80) step();
        check("valid_latency", since, 57);
        check("valid_count", valid_cnt, 1);
        check($sformatf("sar_data_%02h", vin), int'(bus_a.sar_data), int'(vin));
        check("busy_at_valid", int'(bus_a.busy), 1);
        step();
        check("valid_single", int'(bus_a.data_valid), 0);
        check("busy_after", int'(bus_a.busy), 0);
        check("r2r_hold", int'(bus_a.R2R_out), int'(vin));
    endtask

    initial begin
        logic [7:0] v;
        logic       bad;
        int         starts, valids, last_start, prev_start;
        logic       prev_busy;

        bus_a.enable = 1'b1;
        bus_b.enable = 1'b1;
        vin_b = 8'($urandom_range(0, 255));
        repeat (3) @(negedge clk);
        check("rst_r2r", int'(bus_a.R2R_out), 0);
        check("rst_sar", int'(bus_a.sar_data), 0);
        check("rst_valid", int'(bus_a.data_valid), 0);
        check("rst_busy", int'(bus_a.busy), 0);
        reset = 1'b0;

        // Directed codes, the first one also timing the first tick after reset.
        run_conv(8'hA5, 100);
        run_conv(8'h00, -1);
        run_conv(8'hFF, -1);
        run_conv(8'h80, -1);
        run_conv(8'h7F, -1);
        for (int n = 0; n < 6; n++) run_conv(8'($urandom_range(0, 255)), -1);

        // Reset 20 cycles after a tick aborts the conversion.
        vin_a = 8'($urandom_range(1, 255));
        wait_start(-1);
        repeat (19) step();
        reset = 1'b1;
        #1;
        check("abort_r2r", int'(bus_a.R2R_out), 0);
        check("abort_sar", int'(bus_a.sar_data), 0);
        check("abort_busy", int'(bus_a.busy), 0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus_a.data_valid || bus_a.busy) bad = 1'b1;
        end
        check("abort_quiet", int'(bad), 0);
        reset = 1'b0;
        run_conv(8'($urandom_range(0, 255)), 100);

        // Enable low across three ticks: nothing moves.
        v = bus_a.sar_data;
        bus_a.enable = 1'b0;
        bad = 1'b0;
        repeat (320) begin
            @(negedge clk);
            if (bus_a.busy || bus_a.data_valid) bad = 1'b1;
        end
        check("disabled_quiet", int'(bad), 0);
        check("disabled_sar", int'(bus_a.sar_data), int'(v));
        check("disabled_r2r", int'(bus_a.R2R_out), int'(v));

        // Dropping enable mid-conversion lets it finish but blocks the next start.
        bus_a.enable = 1'b1;
        v = 8'($urandom_range(0, 255));
        vin_a = v;
        wait_start(-1);
        repeat (10) step();
        bus_a.enable = 1'b0;
        while (!bus_a.data_valid && since < 80) step();
        check("late_disable_latency", since, 57);
        check("late_disable_sar", int'(bus_a.sar_data), int'(v));
        bad = 1'b0;
        step();
        repeat (150) begin
            @(negedge clk);
            if (bus_a.busy) bad = 1'b1;
        end
        check("late_disable_no_restart", int'(bad), 0);

        // Short sample period: ticks during a conversion are dropped, not queued.
        starts = 0;
        while (bus_b.busy && starts < 100) begin @(negedge clk); starts++; end
        starts = 0;
        while (!bus_b.busy && starts < 100) begin @(negedge clk); starts++; end
        check("b_start_seen", int'(bus_b.busy), 1);
        starts = 0;
        valids = 0;
        last_start = 0;
        prev_start = 0;
        prev_busy = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus_b.busy && !prev_busy) begin
                starts++;
                check("b_start_spacing", i - prev_start, 80);
                prev_start = i;
                last_start = i;
            end
            if (bus_b.data_valid) begin
                valids++;
                check("b_valid_offset", i - last_start, 57);
                check("b_sar_data", int'(bus_b.sar_data), int'(vin_b));
            end
            prev_busy = bus_b.busy;
        end
        check("b_starts", starts, 2);
        check("b_valids", valids, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
